// File: rtl/act_sram_reader.sv
// Streams a contiguous block of activation words out of a single-port SRAM
// onto a valid/ready interface. Reads are throttled so that words already
// buffered plus the read in flight never exceed the 2-entry output FIFO.
//
// state  | meaning
// IDLE   | waiting for start; rejects illegal requests with err
// STREAM | issuing SRAM reads, one per cycle when buffer space allows
// DRAIN  | all reads issued; waiting for the out_last handshake
module act_sram_reader #(
  parameter int CH_NUM       = 3,
  parameter int ACT_PER_ADDR = 9,
  parameter int BW_PER_ACT   = 10,
  parameter int DEPTH        = 80,
  localparam int W           = CH_NUM * ACT_PER_ADDR * BW_PER_ACT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [6:0]   base_addr,
  input  logic [6:0]   word_cnt,
  output logic         sram_csb,
  output logic         sram_wsb,
  output logic [6:0]   sram_raddr,
  input  logic [W-1:0] sram_rdata,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam logic [7:0] DEPTH_L   = 8'(DEPTH);
  localparam logic [6:0] LAST_ADDR = 7'(DEPTH - 1);

  state_e       state_q, state_d;
  logic         csb_q, csb_d;
  logic [6:0]   raddr_q, raddr_d;
  logic [6:0]   rem_q, rem_d;          // reads still to issue after the one on the bus
  logic [6:0]   out_rem_q, out_rem_d;  // words still to hand downstream
  logic         inflight_q, inflight_d;
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic         start_legal;
  logic         pop;
  logic         fifo_write;
  logic         fifo_pop;
  logic         can_issue;
  logic [2:0]   held_next;

  // Output FIFO with bypass: a returning word goes straight to the output
  // when the FIFO is empty, so the first word appears in the data cycle.
  always_comb begin
    out_valid = (count_q != 2'd0) | inflight_q;
    if (count_q != 2'd0) begin
      out_data = mem_q[rd_ptr_q];
    end else if (inflight_q) begin
      out_data = sram_rdata;
    end else begin
      out_data = '0;
    end
    out_last   = out_valid & (out_rem_q == 7'd1);
    pop        = out_valid & out_ready;
    fifo_pop   = pop & (count_q != 2'd0);
    fifo_write = inflight_q & ~(pop & (count_q == 2'd0));
    count_d    = count_q + {1'b0, fifo_write} - {1'b0, fifo_pop};
    wr_ptr_d   = wr_ptr_q ^ fifo_write;
    rd_ptr_d   = rd_ptr_q ^ fifo_pop;
    mem_d      = mem_q;
    if (fifo_write) begin
      mem_d[wr_ptr_q] = sram_rdata;
    end
    inflight_d = ~csb_q;
    // A new read may go out only if, after this edge, at most one word is
    // buffered or in flight; its data then always finds a free FIFO slot.
    held_next  = {1'b0, count_d} + {2'b00, inflight_d};
    can_issue  = (held_next <= 3'd1);
  end

  // Sequencing FSM: next state, read issue, address and word counters.
  always_comb begin
    state_d     = state_q;
    csb_d       = 1'b1;
    raddr_d     = raddr_q;
    rem_d       = rem_q;
    out_rem_d   = out_rem_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    start_legal = ({1'b0, base_addr} < DEPTH_L) && ({1'b0, word_cnt} <= DEPTH_L);
    if (pop) begin
      out_rem_d = out_rem_q - 7'd1;
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!start_legal) begin
            err_d = 1'b1;
          end else if (word_cnt == 7'd0) begin
            done_d = 1'b1;
          end else begin
            state_d   = STREAM;
            csb_d     = 1'b0;
            raddr_d   = base_addr;
            rem_d     = word_cnt - 7'd1;
            out_rem_d = word_cnt;
          end
        end
      end
      STREAM: begin
        if (rem_q == 7'd0) begin
          state_d = DRAIN;
        end else if (can_issue) begin
          csb_d   = 1'b0;
          raddr_d = (raddr_q == LAST_ADDR) ? 7'd0 : raddr_q + 7'd1;
          rem_d   = rem_q - 7'd1;
        end
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers; reset aborts any block in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      csb_q      <= 1'b1;
      raddr_q    <= 7'd0;
      rem_q      <= 7'd0;
      out_rem_q  <= 7'd0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      csb_q      <= csb_d;
      raddr_q    <= raddr_d;
      rem_q      <= rem_d;
      out_rem_q  <= out_rem_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // FIFO storage; contents are don't-care while count is zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign sram_csb   = csb_q;
  assign sram_wsb   = 1'b1;
  assign sram_raddr = raddr_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_act_sram_reader.sv
// Bench for act_sram_reader: SRAM model, scoreboard of expected words and
// addresses per block, and directed timing checks.
module tb_act_sram_reader;

  localparam int W     = 270;
  localparam int DEPTH = 80;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [6:0]   base_addr = 7'd0;
  logic [6:0]   word_cnt = 7'd0;
  logic         sram_csb;
  logic         sram_wsb;
  logic [6:0]   sram_raddr;
  logic [W-1:0] sram_rdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         err;

  act_sram_reader #(
    .CH_NUM(3), .ACT_PER_ADDR(9), .BW_PER_ACT(10), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_cnt(word_cnt), .sram_csb(sram_csb), .sram_wsb(sram_wsb),
    .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         last;
  } exp_t;

  logic [W-1:0] mem [DEPTH];
  exp_t         exp_data[$];
  int           exp_addr[$];
  int           obs_addr[$];
  int           errors = 0;
  int           checks = 0;
  int           rd_issued = 0;
  int           hs_count = 0;
  int           h0;
  bit           stall_prev = 0;
  logic [W-1:0] prev_data;
  logic         prev_last;
  int           lit21 [5] = '{0, 1, 2, 3, 4};
  int           lit22 [4] = '{78, 79, 0, 1};

  function automatic logic [W-1:0] rand_word();
    logic [287:0] t;
    for (int i = 0; i < 9; i++) t[i*32 +: 32] = $urandom();
    return t[W-1:0];
  endfunction

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // SRAM model: data for a read appears in the cycle after it is issued;
  // other cycles carry garbage so a mistimed capture is visible.
  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= mem[int'(sram_raddr)];
    else           sram_rdata <= rand_word();
  end

  // Compare process: every cycle, check reads and output words against the
  // scoreboard, output stability under stall and buffer bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_csb", W'(sram_csb), W'(1));
      check("rst_valid", W'(out_valid), W'(0));
      check("rst_data", out_data, '0);
      exp_data.delete();
      exp_addr.delete();
      rd_issued  = 0;
      hs_count   = 0;
      stall_prev = 0;
    end else begin
      check("wsb_high", W'(sram_wsb), W'(1));
      check("held_le2", W'((rd_issued - hs_count) <= 2), W'(1));
      if (!sram_csb) begin
        rd_issued++;
        obs_addr.push_back(int'(sram_raddr));
        if (exp_addr.size() == 0) begin
          check("unexpected_read", W'(1), W'(0));
        end else begin
          check("raddr", W'(sram_raddr), W'(exp_addr.pop_front()));
        end
      end
      if (out_valid) begin
        if (exp_data.size() == 0) begin
          check("unexpected_word", W'(1), W'(0));
        end else begin
          check("out_data", out_data, exp_data[0].d);
          check("out_last", W'(out_last), W'(exp_data[0].last));
        end
        if (stall_prev) begin
          check("stall_data", out_data, prev_data);
          check("stall_last", W'(out_last), W'(prev_last));
        end
        if (out_ready) begin
          if (exp_data.size() != 0) void'(exp_data.pop_front());
          hs_count++;
          stall_prev = 0;
        end else begin
          stall_prev = 1;
          prev_data  = out_data;
          prev_last  = out_last;
        end
      end else begin
        check("idle_data", out_data, '0);
        check("idle_last", W'(out_last), W'(0));
        if (stall_prev) check("stall_dropped", W'(1), W'(0));
        stall_prev = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input int b, input int c, input bit expect_blk);
    exp_t e;
    base_addr = 7'(b);
    word_cnt  = 7'(c);
    start     = 1'b1;
    if (expect_blk) begin
      for (int i = 0; i < c; i++) begin
        exp_addr.push_back((b + i) % DEPTH);
        e.d    = mem[(b + i) % DEPTH];
        e.last = (i == c - 1);
        exp_data.push_back(e);
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_seen", W'(seen), W'(1));
    if (seen) check("busy_at_done", W'(busy), W'(0));
    tick();
    check("words_left", W'(exp_data.size()), W'(0));
    check("reads_left", W'(exp_addr.size()), W'(0));
  endtask

  task automatic wait_hs(input int n, input string nm);
    for (int i = 0; i < 40 && (hs_count - h0) < n; i++) tick();
    check(nm, W'((hs_count - h0) >= n), W'(1));
  endtask

  task automatic run_req21(input string nm);
    obs_addr.delete();
    start_block(0, 5, 1);
    @(negedge clk);
    check({nm, "_c1_csb"}, W'(sram_csb), W'(0));
    check({nm, "_c1_raddr"}, W'(sram_raddr), W'(0));
    check({nm, "_c1_busy"}, W'(busy), W'(1));
    check({nm, "_c1_valid"}, W'(out_valid), W'(0));
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      check({nm, "_valid"}, W'(out_valid), W'(1));
      check({nm, "_last"}, W'(out_last), W'(c == 6));
      check({nm, "_csb"}, W'(sram_csb), W'(c >= 6));
    end
    @(negedge clk);
    check({nm, "_done"}, W'(done), W'(1));
    check({nm, "_busy_low"}, W'(busy), W'(0));
    check({nm, "_valid_low"}, W'(out_valid), W'(0));
    tick();
    check({nm, "_nreads"}, W'(obs_addr.size()), W'(5));
    for (int i = 0; i < 5 && i < obs_addr.size(); i++)
      check({nm, "_addr_lit"}, W'(obs_addr[i]), W'(lit21[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = rand_word();
    repeat (2) @(negedge clk);
    check("reset_raddr", W'(sram_raddr), W'(0));
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_err", W'(err), W'(0));
    tick();
    rst_n = 1'b1;
    tick();

    // Basic block, ready held high: exact cycle timing.
    run_req21("r21");

    // Address wrap at the top of the SRAM.
    obs_addr.delete();
    start_block(78, 4, 1);
    wait_done(40);
    check("r22_nreads", W'(obs_addr.size()), W'(4));
    for (int i = 0; i < 4 && i < obs_addr.size(); i++)
      check("r22_addr_lit", W'(obs_addr[i]), W'(lit22[i]));

    // Downstream stall for 3 cycles after the second word.
    obs_addr.delete();
    h0 = hs_count;
    start_block(10, 8, 1);
    wait_hs(2, "r23_reach2");
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("r23_valid_held", W'(out_valid), W'(1));
      tick();
    end
    out_ready = 1'b1;
    wait_done(60);
    check("r23_delivered", W'(hs_count - h0), W'(8));
    check("r23_nreads", W'(obs_addr.size()), W'(8));

    // Illegal starts and the empty block.
    start_block(80, 5, 0);
    @(negedge clk);
    check("r24a_err", W'(err), W'(1));
    check("r24a_busy", W'(busy), W'(0));
    check("r24a_csb", W'(sram_csb), W'(1));
    check("r24a_done", W'(done), W'(0));
    @(negedge clk);
    check("r24a_err_pulse", W'(err), W'(0));
    tick();
    start_block(0, 81, 0);
    @(negedge clk);
    check("r24b_err", W'(err), W'(1));
    check("r24b_busy", W'(busy), W'(0));
    check("r24b_csb", W'(sram_csb), W'(1));
    @(negedge clk);
    check("r24b_err_pulse", W'(err), W'(0));
    tick();
    start_block(5, 0, 0);
    @(negedge clk);
    check("r24c_done", W'(done), W'(1));
    check("r24c_err", W'(err), W'(0));
    check("r24c_busy", W'(busy), W'(0));
    check("r24c_csb", W'(sram_csb), W'(1));
    @(negedge clk);
    check("r24c_done_pulse", W'(done), W'(0));
    tick();

    // Second start while busy is ignored.
    obs_addr.delete();
    start_block(30, 4, 1);
    base_addr = 7'd50;
    word_cnt  = 7'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("r25a_err", W'(err), W'(0));
    check("r25a_busy", W'(busy), W'(1));
    wait_done(40);
    check("r25a_nreads", W'(obs_addr.size()), W'(4));
    for (int i = 0; i < 4 && i < obs_addr.size(); i++)
      check("r25a_addr", W'(obs_addr[i]), W'(30 + i));

    // Reset in the middle of a block.
    h0 = hs_count;
    start_block(20, 6, 1);
    wait_hs(2, "r25b_reach2");
    rst_n = 1'b0;
    #1;
    check("r25b_csb", W'(sram_csb), W'(1));
    check("r25b_wsb", W'(sram_wsb), W'(1));
    check("r25b_raddr", W'(sram_raddr), W'(0));
    check("r25b_valid", W'(out_valid), W'(0));
    check("r25b_data", out_data, '0);
    check("r25b_last", W'(out_last), W'(0));
    check("r25b_busy", W'(busy), W'(0));
    check("r25b_done", W'(done), W'(0));
    check("r25b_err", W'(err), W'(0));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("r25b_no_done", W'(done), W'(0));
      check("r25b_no_valid", W'(out_valid), W'(0));
      check("r25b_no_read", W'(sram_csb), W'(1));
    end
    tick();
    run_req21("r25c");

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/act_sram_reader.md
ACT_SRAM_READER -- requirements
Module: act_sram_reader

Interface
REQ-001 SHALL have parameters: CH_NUM, default 3, channels per word; ACT_PER_ADDR, default 9, activations per channel per word; BW_PER_ACT, default 10, bits per activation; DEPTH, default 80, SRAM words.
REQ-002 SHALL define W = CH_NUM*ACT_PER_ADDR*BW_PER_ACT (270 by default).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Ports:
 clk  input  1  rising-edge clock
 rst_n  input  1  asynchronous active-low reset
 start  input  1  one-cycle request to stream a block
 base_addr  input  7  first SRAM word address, sampled with start
 word_cnt  input  7  number of words to stream (0..DEPTH), sampled with start
 sram_csb  output  1  SRAM chip enable, active-low; low issues a read
 sram_wsb  output  1  SRAM write enable, active-low; constant 1
 sram_raddr  output  7  SRAM read address
 sram_rdata  input  W  SRAM read data, valid in the cycle after a read is issued
 out_valid  output  1  out_data holds a word
 out_ready  input  1  downstream accepts the word
 out_data  output  W  streamed word, SRAM bit order
 out_last  output  1  high with the final word of the block
 busy  output  1  block in progress
 done  output  1  one-cycle pulse, block complete
 err  output  1  one-cycle pulse, illegal start rejected

Function
REQ-005 SHALL implement FSM states IDLE, STREAM, DRAIN; IDLE->STREAM on legal start with word_cnt>0; STREAM->DRAIN when all reads issued; DRAIN->IDLE on handshake of the out_last word.
REQ-006 Start is legal only in IDLE with base_addr<=DEPTH-1 and word_cnt<=DEPTH; start outside IDLE SHALL be ignored with no err.
REQ-007 Illegal start in IDLE SHALL pulse err in the next cycle, issue no reads, and leave busy low.
REQ-008 Legal start with word_cnt=0 SHALL pulse done in the next cycle, issue no reads, and leave busy low.
REQ-009 Legal start with word_cnt>0 sampled at edge k SHALL drive sram_csb=0, sram_raddr=base_addr in the cycle after edge k; busy SHALL rise in that cycle.
REQ-010 Read addresses SHALL increment by 1 per issued read, wrapping DEPTH-1 -> 0; exactly word_cnt reads per block.
REQ-011 sram_csb SHALL be high in every cycle no read is issued; sram_raddr holds its last value when csb is high.
REQ-012 sram_rdata SHALL be captured only in the cycle after an issued read (one in-flight flag), into a 2-entry FIFO.
REQ-013 Reads SHALL be issued only when FIFO occupancy + in-flight reads - (pop this cycle) <= 1; FIFO never overflows, no word dropped or duplicated.
REQ-014 With out_ready held high, reads SHALL issue every cycle and out_valid SHALL be high every cycle, first word 2 cycles after start edge.
REQ-015 out_valid/out_data/out_last SHALL stay stable while out_valid=1 and out_ready=0.
REQ-016 Handshake occurs at an edge with out_valid=1 and out_ready=1; out_last=1 exactly on the word_cnt-th word.
REQ-017 done SHALL pulse and busy SHALL fall in the cycle after the out_last handshake; new start accepted from that cycle.
REQ-018 out_data SHALL be 0 when out_valid=0.

Reset
REQ-019 rst_n low SHALL immediately force: FSM IDLE, FIFO empty, in-flight cleared, sram_csb=1, sram_wsb=1, sram_raddr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0.
REQ-020 Reset mid-block SHALL abort the block; SRAM data returning after reset deassertion SHALL be discarded; no done pulse.

Verification
REQ-021 base=0, cnt=5, ready=1 -> csb low 5 consecutive cycles, raddr 0,1,2,3,4; out_valid 5 consecutive cycles starting 2 cycles after start; out_last on 5th; done next cycle.
REQ-022 base=78, cnt=4 -> raddr 78,79,0,1; out_data equals those words in order.
REQ-023 base=10, cnt=8, ready low 3 cycles after 2nd word -> out_data stable while stalled, at most 2 words buffered, all 8 words delivered once in order.
REQ-024 start base=80 or cnt=81 -> err pulse next cycle, csb stays high, busy 0; start cnt=0 -> done pulse only.
REQ-025 start pulsed again while busy -> ignored, block unchanged; rst_n low during word 3 of cnt=6 -> all outputs reset values, no done, next start behaves per REQ-021.
